alu_unit: RTL
=============

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ready, input, 1 bit: global enable; when low, all state holds.
REQ-004 SHALL have port clear, input, 1 bit: flush from ROB on mispredict.
REQ-005 SHALL have port in_flag, input, 1 bit: a valid instruction is presented this cycle by the reservation station.
REQ-006 SHALL have ports in_op (6 bits), in_imm (32), in_pc (32), in_robpos (4), in_vj (32), in_vk (32): the issued instruction and its resolved operands.
REQ-007 SHALL have port out_flag, output, 1 bit: result valid, broadcast to RS, LSB and ROB.
REQ-008 SHALL have ports out_val (32), out_robpos (4), out_jump (1, branch/jump taken), out_target (32, redirect PC): all outputs.
REQ-009 SHALL have port alu_busy, output, 1 bit: RS must not issue this cycle; tied to 0 when MUL_EN is undefined.

Function
REQ-010 SHALL register every result: in_flag at edge N gives out_flag high for exactly the cycle after edge N (latency 1) for all non-multiply ops.
REQ-011 SHALL compute ADD/SUB/AND/OR/XOR/SLT/SLTU/SLL/SRL/SRA on (vj, vk), and the immediate forms on (vj, imm); shift amount = low 5 bits.
REQ-012 SHALL compute LUI -> imm; AUIPC -> pc+imm; JAL -> val pc+4, jump 1, target pc+imm; JALR -> val pc+4, jump 1, target (vj+imm) with bit0 cleared.
REQ-013 SHALL compute BEQ/BNE/BLT/BGE/BLTU/BGEU: out_jump = condition, out_target = pc+imm if taken else pc+4, out_val = 0.
REQ-014 SHALL drive out_jump = 0 and out_target = pc+4 for non-control ops.
REQ-015 SHALL use 32-bit wrap-around arithmetic; signed ops compare in two's complement.
REQ-016 SHALL, when ready is low, hold out_flag and all outputs unchanged and ignore in_flag.
REQ-017 SHALL, on clear (with ready high), drop out_flag to 0 next cycle, discard any in-flight multiply, and ignore in_flag that cycle.
REQ-018 SHALL treat an unknown in_op as ADD with out_jump 0.

Reset
REQ-019 SHALL on reset drive out_flag, out_jump, alu_busy to 0 and out_val, out_robpos, out_target to 0; multiply pipeline empty.
REQ-020 SHALL have reset take priority over clear and ready.

Configuration
REQ-021 SHALL with RV32M_MUL_EN defined accept MUL/MULH/MULHSU/MULHU via a 3-cycle state machine IDLE -> M1 -> M2 -> DONE -> IDLE; alu_busy high in M1, M2; result with out_flag in DONE.
REQ-022 SHALL with RV32M_MUL_EN defined give a multiply priority for out_flag; RS guarantees no in_flag while alu_busy is high, and in_flag in DONE is accepted normally (result next cycle).
REQ-023 SHALL without RV32M_MUL_EN treat multiply opcodes per REQ-018 and contain no multiplier logic.

Structure
REQ-024 SHALL take opcode encodings and width constants (DATA, ADDR, IMM, ROB index, OP) from the shared definitions include; no local encodings.
REQ-025 SHALL place the multiplier in sub-module alu_mul (operands, signedness, start in; product high/low, done out), instantiated only under RV32M_MUL_EN.

Verification
REQ-026 SHALL check: ADD vj=0xFFFFFFFF, vk=1 -> next cycle out_flag=1, out_val=0, out_robpos echoed.
REQ-027 SHALL check: SRA vj=0x80000000, vk=0x24 -> out_val=0xF8000000 (shamt 4).
REQ-028 SHALL check: BLT pc=0x100, imm=0x20, vj=-1, vk=1 -> jump=1, target=0x120; BLTU same operands -> jump=0, target=0x104.
REQ-029 SHALL check: JALR pc=0x40, vj=0x1001, imm=2 -> val=0x44, target=0x1002, jump=1.
REQ-030 SHALL check: in_flag with ready low for 3 cycles -> no out_flag, outputs held; clear in cycle after issue -> out_flag 0.
REQ-031 SHALL check (RV32M_MUL_EN): MULHU 0xFFFFFFFF x 0xFFFFFFFF -> alu_busy 2 cycles, then out_val=0xFFFFFFFE with out_flag for 1 cycle.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared widths, opcode encodings and result helpers for the integer ALU.
// Multiply opcodes are decoded only when the top is built with RV32M_MUL_EN.
package alu_unit_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int IMM_W  = 32;
   localparam int ROB_W  = 4;
   localparam int OP_W   = 6;

   localparam logic [OP_W-1:0] OP_ADD    = 6'd0;
   localparam logic [OP_W-1:0] OP_SUB    = 6'd1;
   localparam logic [OP_W-1:0] OP_AND    = 6'd2;
   localparam logic [OP_W-1:0] OP_OR     = 6'd3;
   localparam logic [OP_W-1:0] OP_XOR    = 6'd4;
   localparam logic [OP_W-1:0] OP_SLT    = 6'd5;
   localparam logic [OP_W-1:0] OP_SLTU   = 6'd6;
   localparam logic [OP_W-1:0] OP_SLL    = 6'd7;
   localparam logic [OP_W-1:0] OP_SRL    = 6'd8;
   localparam logic [OP_W-1:0] OP_SRA    = 6'd9;
   localparam logic [OP_W-1:0] OP_ADDI   = 6'd10;
   localparam logic [OP_W-1:0] OP_ANDI   = 6'd11;
   localparam logic [OP_W-1:0] OP_ORI    = 6'd12;
   localparam logic [OP_W-1:0] OP_XORI   = 6'd13;
   localparam logic [OP_W-1:0] OP_SLTI   = 6'd14;
   localparam logic [OP_W-1:0] OP_SLTIU  = 6'd15;
   localparam logic [OP_W-1:0] OP_SLLI   = 6'd16;
   localparam logic [OP_W-1:0] OP_SRLI   = 6'd17;
   localparam logic [OP_W-1:0] OP_SRAI   = 6'd18;
   localparam logic [OP_W-1:0] OP_LUI    = 6'd19;
   localparam logic [OP_W-1:0] OP_AUIPC  = 6'd20;
   localparam logic [OP_W-1:0] OP_JAL    = 6'd21;
   localparam logic [OP_W-1:0] OP_JALR   = 6'd22;
   localparam logic [OP_W-1:0] OP_BEQ    = 6'd23;
   localparam logic [OP_W-1:0] OP_BNE    = 6'd24;
   localparam logic [OP_W-1:0] OP_BLT    = 6'd25;
   localparam logic [OP_W-1:0] OP_BGE    = 6'd26;
   localparam logic [OP_W-1:0] OP_BLTU   = 6'd27;
   localparam logic [OP_W-1:0] OP_BGEU   = 6'd28;
   localparam logic [OP_W-1:0] OP_MUL    = 6'd29;
   localparam logic [OP_W-1:0] OP_MULH   = 6'd30;
   localparam logic [OP_W-1:0] OP_MULHSU = 6'd31;
   localparam logic [OP_W-1:0] OP_MULHU  = 6'd32;

   typedef enum logic [1:0] {MUL_IDLE, MUL_M1, MUL_M2, MUL_DONE} mul_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] val;
      logic              jump;
      logic [ADDR_W-1:0] target;
   } alu_res_t;

   function automatic logic is_imm_op(input logic [OP_W-1:0] op);
      return op inside {[OP_ADDI:OP_SRAI]};
   endfunction

   function automatic logic is_mul_op(input logic [OP_W-1:0] op);
      return op inside {[OP_MUL:OP_MULHU]};
   endfunction

   // Conditional branches write no register value and redirect only when taken.
   function automatic alu_res_t branch_res(input logic taken,
                                           input logic [ADDR_W-1:0] tgt_taken,
                                           input logic [ADDR_W-1:0] tgt_fall);
      alu_res_t r;
      r.val    = '0;
      r.jump   = taken;
      r.target = taken ? tgt_taken : tgt_fall;
      return r;
   endfunction

endpackage

// File: rtl/alu_unit_mul.sv
// Two-stage 33x33 signed multiplier: operands registered in p1, product in p2.
// Only instantiated by alu_unit when RV32M_MUL_EN is defined.
module alu_mul
   import alu_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   input  logic              clear,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              a_signed,
   input  logic              b_signed,
   output logic [DATA_W-1:0] prod_hi,
   output logic [DATA_W-1:0] prod_lo,
   output logic              done
);

   logic vld_p1, vld_p2;
   logic signed [2*DATA_W-1:0] a_p1, b_p1, prod_p2;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (ready) begin
         vld_p1 <= start & ~clear;
         vld_p2 <= vld_p1 & ~clear;
      end
   end

   // p1: sign- or zero-extend operands so one signed multiply covers all four ops
   always_ff @(posedge clk) begin
      if (ready && start) begin
         a_p1 <= {{DATA_W{a_signed & a[DATA_W-1]}}, a};
         b_p1 <= {{DATA_W{b_signed & b[DATA_W-1]}}, b};
      end
   end

   // p2: product
   always_ff @(posedge clk) begin
      if (ready && vld_p1) begin
         prod_p2 <= a_p1 * b_p1;
      end
   end

   assign prod_hi = prod_p2[2*DATA_W-1:DATA_W];
   assign prod_lo = prod_p2[DATA_W-1:0];
   assign done    = vld_p2;

endmodule

// File: rtl/alu_unit.sv
// Single-cycle integer ALU with branch resolution for the out-of-order core.
// Define RV32M_MUL_EN to add the 3-cycle multiply path (alu_mul) and alu_busy.
module alu_unit
   import alu_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   input  logic              clear,
   input  logic              in_flag,
   input  logic [OP_W-1:0]   in_op,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [ROB_W-1:0]  in_robpos,
   input  logic [DATA_W-1:0] in_vj,
   input  logic [DATA_W-1:0] in_vk,
   output logic              out_flag,
   output logic [DATA_W-1:0] out_val,
   output logic [ROB_W-1:0]  out_robpos,
   output logic              out_jump,
   output logic [ADDR_W-1:0] out_target,
   output logic              alu_busy
);

   logic [ADDR_W-1:0]        pc_4, pc_imm;
   logic [DATA_W-1:0]        opb;
   logic [4:0]               shamt;
   logic signed [DATA_W-1:0] vj_s, opb_s, vk_s;
   alu_res_t                 res_c, wr_res_c;
   logic                     wr_flag_c;
   logic [ROB_W-1:0]         wr_rob_c;

   assign pc_4   = in_pc + 32'd4;
   assign pc_imm = in_pc + in_imm;
   assign opb    = is_imm_op(in_op) ? in_imm : in_vk;
   assign shamt  = opb[4:0];
   assign vj_s   = in_vj;
   assign opb_s  = opb;
   assign vk_s   = in_vk;

   always_comb begin
      res_c.val    = in_vj + opb;
      res_c.jump   = 1'b0;
      res_c.target = pc_4;
      case (in_op)
         OP_SUB:            res_c.val = in_vj - opb;
         OP_AND,  OP_ANDI:  res_c.val = in_vj & opb;
         OP_OR,   OP_ORI:   res_c.val = in_vj | opb;
         OP_XOR,  OP_XORI:  res_c.val = in_vj ^ opb;
         OP_SLT,  OP_SLTI:  res_c.val = {{(DATA_W-1){1'b0}}, vj_s < opb_s};
         OP_SLTU, OP_SLTIU: res_c.val = {{(DATA_W-1){1'b0}}, in_vj < opb};
         OP_SLL,  OP_SLLI:  res_c.val = in_vj << shamt;
         OP_SRL,  OP_SRLI:  res_c.val = in_vj >> shamt;
         OP_SRA,  OP_SRAI:  res_c.val = vj_s >>> shamt;
         OP_LUI:            res_c.val = in_imm;
         OP_AUIPC:          res_c.val = pc_imm;
         OP_JAL: begin
            res_c.val    = pc_4;
            res_c.jump   = 1'b1;
            res_c.target = pc_imm;
         end
         OP_JALR: begin
            res_c.val    = pc_4;
            res_c.jump   = 1'b1;
            res_c.target = (in_vj + in_imm) & ~32'd1;
         end
         OP_BEQ:  res_c = branch_res(in_vj == in_vk, pc_imm, pc_4);
         OP_BNE:  res_c = branch_res(in_vj != in_vk, pc_imm, pc_4);
         OP_BLT:  res_c = branch_res(vj_s <  vk_s,   pc_imm, pc_4);
         OP_BGE:  res_c = branch_res(vj_s >= vk_s,   pc_imm, pc_4);
         OP_BLTU: res_c = branch_res(in_vj <  in_vk, pc_imm, pc_4);
         OP_BGEU: res_c = branch_res(in_vj >= in_vk, pc_imm, pc_4);
         default: ;
      endcase
   end

`ifdef RV32M_MUL_EN
   mul_state_e        state, state_nxt;
   logic              take_c, mul_start_c, mul_fin_c, mul_done;
   logic [DATA_W-1:0] prod_hi, prod_lo;
   logic              mul_hi_p1;
   logic [ROB_W-1:0]  mul_rob_p1;
   logic [ADDR_W-1:0] mul_tgt_p1;

   alu_mul u_mul (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .clear    (clear),
      .start    (mul_start_c),
      .a        (in_vj),
      .b        (in_vk),
      .a_signed ((in_op == OP_MULH) || (in_op == OP_MULHSU)),
      .b_signed (in_op == OP_MULH),
      .prod_hi  (prod_hi),
      .prod_lo  (prod_lo),
      .done     (mul_done)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= MUL_IDLE;
      else if (ready) state <= state_nxt;
   end

   // The finishing multiply owns the result bus; new issue is taken only in IDLE/DONE.
   always_comb begin
      state_nxt   = state;
      take_c      = 1'b0;
      mul_start_c = 1'b0;
      mul_fin_c   = 1'b0;
      if (clear) begin
         state_nxt = MUL_IDLE;
      end else begin
         case (state)
            MUL_IDLE, MUL_DONE: begin
               take_c      = in_flag;
               mul_start_c = in_flag & is_mul_op(in_op);
               state_nxt   = mul_start_c ? MUL_M1 : MUL_IDLE;
            end
            MUL_M1: state_nxt = MUL_M2;
            MUL_M2: begin
               mul_fin_c = mul_done;
               if (mul_done) state_nxt = MUL_DONE;
            end
            default: state_nxt = MUL_IDLE;
         endcase
      end
      wr_flag_c       = mul_fin_c | (take_c & ~mul_start_c);
      wr_res_c        = res_c;
      wr_rob_c        = in_robpos;
      if (mul_fin_c) begin
         wr_res_c.val    = mul_hi_p1 ? prod_hi : prod_lo;
         wr_res_c.jump   = 1'b0;
         wr_res_c.target = mul_tgt_p1;
         wr_rob_c        = mul_rob_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (ready && mul_start_c) begin
         mul_hi_p1  <= (in_op != OP_MUL);
         mul_rob_p1 <= in_robpos;
         mul_tgt_p1 <= pc_4;
      end
   end

   assign alu_busy = (state == MUL_M1) || (state == MUL_M2);
`else
   assign wr_flag_c = in_flag & ~clear;
   assign wr_res_c  = res_c;
   assign wr_rob_c  = in_robpos;
   assign alu_busy  = 1'b0;
`endif

   // p1: registered result broadcast
   always_ff @(posedge clk) begin
      if (reset) begin
         out_flag   <= 1'b0;
         out_val    <= '0;
         out_robpos <= '0;
         out_jump   <= 1'b0;
         out_target <= '0;
      end else if (ready) begin
         out_flag <= wr_flag_c;
         if (wr_flag_c) begin
            out_val    <= wr_res_c.val;
            out_robpos <= wr_rob_c;
            out_jump   <= wr_res_c.jump;
            out_target <= wr_res_c.target;
         end
      end
   end

endmodule
